// File: rtl/table_ram_if.sv
// Bus bundle for table_ram: zero-fill control, read port and write port.
// The master side (user logic or bench) drives requests; the slave side
// (table_ram) returns busy, read data and read-valid.
interface table_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 5
) ();

  logic                  clr;
  logic                  busy;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  winc;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (
    output clr, ren, raddr, winc, waddr, wdata,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, ren, raddr, winc, waddr, wdata,
    output busy, rdata, rvalid
  );

endinterface

// File: rtl/ram_sdp.sv
// Plain simple dual-port array: one synchronous write port and one
// registered read port. No reset on the array or the read register, so the
// tools can map it onto block RAM. A read and a write to the same address in
// the same cycle return the old contents.
module ram_sdp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store one word when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered read of the addressed word (read-before-write).
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/table_ram.sv
// Lookup-table RAM with self-clearing array. After reset release, or on a
// clr pulse, every word is overwritten with zero (one word per cycle) while
// busy is high; user reads and writes are ignored during that time. In idle,
// reads return data after 1+OUT_REG cycles with a one-cycle rvalid, and an
// optional write-first forwarding path resolves same-address collisions.
module table_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 5,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  table_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [0:0] CLEAR_ENC = 1'b0;
  localparam logic [0:0] IDLE_ENC  = 1'b1;
  localparam bit BYPASS_EN = (BYPASS != 0);

  typedef enum logic [0:0] {
    ST_CLEAR = CLEAR_ENC,
    ST_IDLE  = IDLE_ENC
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_next_s;
  logic                  busy_r;
  logic                  fill_we_s;

  logic                  acc_rd_s;
  logic                  acc_wr_s;
  logic                  coll_s;

  logic                  ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_waddr_s;
  logic [DATA_WIDTH-1:0] ram_wdata_s;
  logic [DATA_WIDTH-1:0] ram_q_s;

  logic                  rd_v1_r;
  logic                  fwd_hit_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;
  logic [DATA_WIDTH-1:0] data1_s;

  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  rvalid_s;

  // User accesses are only honoured once the fill has finished.
  assign acc_rd_s = bus.ren  & ~busy_r;
  assign acc_wr_s = bus.winc & ~busy_r;
  assign coll_s   = BYPASS_EN & acc_rd_s & acc_wr_s & (bus.raddr == bus.waddr);

  // Next-state logic: fill sequencing, clr restart and terminal-count exit.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    fill_we_s    = 1'b0;
    if (bus.clr) begin
      next_state_s = ST_CLEAR;
      cnt_next_s   = '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          fill_we_s = 1'b1;
          if (cnt_r == LAST_ADDR) begin
            next_state_s = ST_IDLE;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s = cnt_r + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          cnt_next_s = '0;
        end
        default: begin
          next_state_s = ST_CLEAR;
          cnt_next_s   = '0;
        end
      endcase
    end
  end

  // State, fill counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (next_state_s == ST_CLEAR);
    end
  end

  // Write-port mux: the zero fill owns the port while it runs.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    if (fill_we_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_r;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = acc_wr_s;
      ram_waddr_s = bus.waddr;
      ram_wdata_s = bus.wdata;
    end
  end

  ram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (acc_rd_s),
    .raddr (bus.raddr),
    .rdata (ram_q_s)
  );

  // First read stage: valid flag plus captured write data for collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_r    <= 1'b0;
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= '0;
    end else begin
      rd_v1_r   <= acc_rd_s;
      fwd_hit_r <= coll_s;
      if (coll_s) begin
        fwd_data_r <= bus.wdata;
      end
    end
  end

  // Select forwarded write data over the array word on a collision.
  always_comb begin
    data1_s = ram_q_s;
    if (fwd_hit_r) begin
      data1_s = fwd_data_r;
    end else begin
      data1_s = ram_q_s;
    end
  end

  if (OUT_REG == 0) begin : g_direct
    logic [DATA_WIDTH-1:0] hold_r;

    // Remember the last completed read so rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_r <= '0;
      end else if (rd_v1_r) begin
        hold_r <= data1_s;
      end
    end

    // Present fresh data on the completing cycle, otherwise the held value.
    always_comb begin
      rvalid_s = rd_v1_r;
      rdata_s  = hold_r;
      if (rd_v1_r) begin
        rdata_s = data1_s;
      end else begin
        rdata_s = hold_r;
      end
    end
  end else begin : g_piped
    logic                  rd_v2_r;
    logic [DATA_WIDTH-1:0] out_r;

    // Output pipeline stage: one extra cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_v2_r <= 1'b0;
        out_r   <= '0;
      end else begin
        rd_v2_r <= rd_v1_r;
        if (rd_v1_r) begin
          out_r <= data1_s;
        end
      end
    end

    // Drive outputs straight from the pipeline registers.
    always_comb begin
      rvalid_s = rd_v2_r;
      rdata_s  = out_r;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.rdata  = rdata_s;
  assign bus.rvalid = rvalid_s;

endmodule
